// File: rtl/word_char_unpacker_if.sv
// Word-in / character-out handshake bundle for word_char_unpacker.
// slave = unpacker view, master = processor/sink view.
interface word_char_unpacker_if #(
  parameter int WORD_WIDTH = 32,
  parameter int CHAR_WIDTH = 8
);
  localparam int NUM_CHARS = WORD_WIDTH / CHAR_WIDTH;
  localparam int IDX_W     = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

  logic [WORD_WIDTH-1:0] word_in;
  logic                  word_valid;
  logic                  word_ready;
  logic [CHAR_WIDTH-1:0] char_out;
  logic                  char_valid;
  logic                  char_ready;
  logic                  last_char;
  logic [IDX_W-1:0]      char_index;
  logic                  busy;

  modport slave (
    input  word_in, word_valid, char_ready,
    output word_ready, char_out, char_valid, last_char, char_index, busy
  );

  modport master (
    output word_in, word_valid, char_ready,
    input  word_ready, char_out, char_valid, last_char, char_index, busy
  );
endinterface

// File: rtl/word_char_unpacker.sv
// Unpacks a packed word into characters, LSB first, with valid/ready on both sides.
// Optional UNPACK_NULL_TERM_EN: 0x00 terminates the string and is never emitted.
module word_char_unpacker #(
  parameter int WORD_WIDTH = 32,
  parameter int CHAR_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  word_char_unpacker_if.slave  bus
);
  localparam int NUM_CHARS = WORD_WIDTH / CHAR_WIDTH;
  localparam int IDX_W     = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t                r_state, w_state_next;
  logic [WORD_WIDTH-1:0] r_shift, w_shift_next;
  logic [IDX_W-1:0]      r_index, w_index_next;

  logic w_emit;
  logic w_word_ready;
  logic w_accept;
  logic w_load;
  logic w_last_idx;
  logic w_last;

  assign w_emit       = (r_state == S_EMIT);
  assign w_word_ready = (r_state == S_IDLE) && !reset;
  assign w_accept     = bus.word_valid && w_word_ready;
  assign w_last_idx   = (r_index == IDX_W'(NUM_CHARS - 1));

`ifdef UNPACK_NULL_TERM_EN
  logic [CHAR_WIDTH-1:0] w_next_byte;
  assign w_next_byte = CHAR_WIDTH'(r_shift >> CHAR_WIDTH);
  // A word starting with a terminator is an empty string: swallow it.
  assign w_load      = w_accept && (bus.word_in[CHAR_WIDTH-1:0] != '0);
  assign w_last      = w_emit && (w_last_idx || (w_next_byte == '0));
`else
  assign w_load      = w_accept;
  assign w_last      = w_emit && w_last_idx;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_index <= '0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_index <= w_index_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_index_next = r_index;
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_state_next = S_EMIT;
          w_shift_next = bus.word_in;
          w_index_next = '0;
        end
      end
      S_EMIT: begin
        if (bus.char_ready) begin
          if (w_last) begin
            w_state_next = S_IDLE;
            w_shift_next = '0;
            w_index_next = '0;
          end else begin
            w_shift_next = r_shift >> CHAR_WIDTH;
            w_index_next = r_index + IDX_W'(1);
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.word_ready = w_word_ready;
  assign bus.char_valid = w_emit;
  assign bus.char_out   = w_emit ? r_shift[CHAR_WIDTH-1:0] : '0;
  assign bus.last_char  = w_last;
  assign bus.char_index = r_index;
  assign bus.busy       = w_emit;
endmodule

// File: tb/tb_word_char_unpacker.sv
// Self-checking bench for word_char_unpacker: directed table, corner sequences, random vs model.
module tb_word_char_unpacker;
  logic clock;
  logic reset;

  word_char_unpacker_if #(.WORD_WIDTH(32), .CHAR_WIDTH(8)) bus ();

  word_char_unpacker #(.WORD_WIDTH(32), .CHAR_WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] word;
    logic [31:0] exp_chars;  // expected characters packed, first in [7:0]
    int          exp_n;
    int          prob;
    int          stall_idx;
    int          stall_len;
    bit          junk_valid;
  } vec_t;

  vec_t tbl[5];

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endfunction

  // Reference: the sequence of characters a word should produce.
  function automatic void model(input logic [31:0] w, output logic [31:0] chars, output int n);
    logic [7:0] b;
    bit stop;
    chars = '0;
    n = 0;
    stop = 0;
    for (int i = 0; i < 4; i++) begin
      b = 8'((w >> (8 * i)) & 32'hFF);
`ifdef UNPACK_NULL_TERM_EN
      if (b == 8'h00) stop = 1;
`endif
      if (!stop) begin
        chars = chars | (32'(b) << (8 * n));
        n++;
      end
    end
  endfunction

  task automatic run_word(input logic [31:0] word, input logic [31:0] exp_chars, input int exp_n,
                          input int prob, input int stall_idx, input int stall_len,
                          input bit junk_valid);
    int k;
    int cyc;
    int stalled;
    bit rdy;
    bit ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.word_ready) begin
        ok = 1;
        break;
      end
      @(posedge clock); #1;
    end
    check("word_ready_idle", 32'(bus.word_ready), 32'd1);
    check("char_valid_idle", 32'(bus.char_valid), 32'd0);
    if (!ok) return;
    bus.char_ready = 1'($urandom % 2);
    bus.word_in    = word;
    bus.word_valid = 1'b1;
    @(posedge clock); #1;
    bus.word_valid = 1'b0;
    bus.word_in    = $urandom;
    k = 0;
    cyc = 0;
    stalled = 0;
    while (k < exp_n && cyc < 200) begin
      check("char_valid", 32'(bus.char_valid), 32'd1);
      check("char_out", 32'(bus.char_out), (exp_chars >> (8 * k)) & 32'hFF);
      check("char_index", 32'(bus.char_index), 32'(k));
      check("last_char", 32'(bus.last_char), 32'(k == exp_n - 1));
      check("busy", 32'(bus.busy), 32'd1);
      check("word_ready_busy", 32'(bus.word_ready), 32'd0);
      rdy = ($urandom_range(99) < prob);
      if (k == stall_idx && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end
      bus.char_ready = rdy;
      if (junk_valid) begin
        bus.word_valid = 1'b1;
        bus.word_in    = 32'h11111111;
      end
      @(posedge clock); #1;
      if (rdy) k++;
      cyc++;
    end
    bus.word_valid = 1'b0;
    check("char_count", 32'(k), 32'(exp_n));
    check("char_valid_end", 32'(bus.char_valid), 32'd0);
    check("word_ready_end", 32'(bus.word_ready), 32'd1);
    check("busy_end", 32'(bus.busy), 32'd0);
    check("char_out_end", 32'(bus.char_out), 32'd0);
    $display("[TB] word %h: %0d chars expected, %0d transferred in %0d cycles", word, exp_n, k, cyc);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] chars;
    int n;
    int k;

`ifdef UNPACK_NULL_TERM_EN
    tbl[0] = '{32'h6C6C6548, 32'h6C6C6548, 4, 100, -1, 0, 1'b0};
    tbl[1] = '{32'h44434241, 32'h44434241, 4, 100,  1, 3, 1'b0};
    tbl[2] = '{32'h6C6C6548, 32'h6C6C6548, 4, 100, -1, 0, 1'b1};
    tbl[3] = '{32'h00006948, 32'h00006948, 2, 100, -1, 0, 1'b0};
    tbl[4] = '{32'h12340000, 32'h00000000, 0, 100, -1, 0, 1'b0};
`else
    tbl[0] = '{32'h6C6C6548, 32'h6C6C6548, 4, 100, -1, 0, 1'b0};
    tbl[1] = '{32'h44434241, 32'h44434241, 4, 100,  1, 3, 1'b0};
    tbl[2] = '{32'h6C6C6548, 32'h6C6C6548, 4, 100, -1, 0, 1'b1};
    tbl[3] = '{32'h00006948, 32'h00006948, 4, 100, -1, 0, 1'b0};
    tbl[4] = '{32'h12340000, 32'h12340000, 4, 100, -1, 0, 1'b0};
`endif

    reset          = 1'b1;
    bus.word_in    = '0;
    bus.word_valid = 1'b0;
    bus.char_ready = 1'b0;
    #1;
    check("word_ready_in_reset", 32'(bus.word_ready), 32'd0);
    check("char_valid_in_reset", 32'(bus.char_valid), 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("rst_word_ready", 32'(bus.word_ready), 32'd1);
    check("rst_char_valid", 32'(bus.char_valid), 32'd0);
    check("rst_char_out", 32'(bus.char_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_last_char", 32'(bus.last_char), 32'd0);
    check("rst_char_index", 32'(bus.char_index), 32'd0);
    $display("[TB] reset released: word_ready=%0b char_valid=%0b", bus.word_ready, bus.char_valid);
    @(posedge clock); #1;

    for (int i = 0; i < 5; i++)
      run_word(tbl[i].word, tbl[i].exp_chars, tbl[i].exp_n, tbl[i].prob,
               tbl[i].stall_idx, tbl[i].stall_len, tbl[i].junk_valid);

    // Reset in the middle of a word: abandon it and come back idle.
    bus.char_ready = 1'b1;
    bus.word_in    = 32'h64636261;
    bus.word_valid = 1'b1;
    @(posedge clock); #1;
    bus.word_valid = 1'b0;
    for (k = 0; k < 2; k++) begin
      check("midrst_char_out", 32'(bus.char_out), 32'h61 + 32'(k));
      @(posedge clock); #1;
    end
    check("midrst_char_out_pre", 32'(bus.char_out), 32'h63);
    reset = 1'b1;
    #1;
    check("midrst_char_valid", 32'(bus.char_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_word_ready", 32'(bus.word_ready), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("postrst_char_valid", 32'(bus.char_valid), 32'd0);
    check("postrst_char_index", 32'(bus.char_index), 32'd0);
    $display("[TB] reset mid-word applied after 2 chars, char_valid=%0b", bus.char_valid);
`ifdef UNPACK_NULL_TERM_EN
    run_word(32'h00000021, 32'h00000021, 1, 100, -1, 0, 1'b0);
`else
    run_word(32'h00000021, 32'h00000021, 4, 100, -1, 0, 1'b0);
`endif

    // Random words with frequent zero bytes and random backpressure.
    for (int t = 0; t < 300; t++) begin
      w = '0;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(3) != 0) w = w | (32'($urandom_range(255)) << (8 * b));
      model(w, chars, n);
      run_word(w, chars, n, int'($urandom_range(100, 30)), -1, 0, 1'($urandom % 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
